alu_rr_arbiter: RTL and testbench
=================================

Name: alu_rr_arbiter

Overview:
Shares one combinational ALU datapath between two requesters: port 0 is the EX-stage issue and port 1 is the branch/address-compare side path. It performs round-robin arbitration with valid/ready handshakes on both request ports. The selected operands go through the ALU, and the result is registered in a single-entry output stage, so latency is one cycle. Saturating per-port grant counters are provided for performance debug.

Parameters:
DW, 32, operand/result width; the ALU core is fixed at 32, so only 32 is legal.
TAG_W, 5, width of the opaque requester tag returned with the result (e.g. destination register number).
CNT_W, 16, width of the saturating grant counters.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
req0_valid  in  1  port 0 request valid.
req0_ready  out  1  port 0 request accepted this cycle.
req0_a  in  DW  port 0 operand A.
req0_b  in  DW  port 0 operand B.
req0_sel  in  4  port 0 ALU operation code.
req0_tag  in  TAG_W  port 0 tag.
req1_valid, req1_ready, req1_a, req1_b, req1_sel, req1_tag  same as port 0, for port 1.
rsp_valid  out  1  result valid.
rsp_ready  in  1  consumer accepts result.
rsp_data  out  DW  registered ALU result.
rsp_src  out  1  port that issued the result (0/1).
rsp_tag  out  TAG_W  tag of that request.
rsp_illegal  out  1  the issued op code was 11..15 (rsp_data is then 0).
cnt0, cnt1  out  CNT_W  saturating count of accepted requests per port.

Behaviour:
- Reset is synchronous and active-high; clock is clk.
- Reset values:
  - rsp_valid=0, rsp_data=0, rsp_src=0, rsp_tag=0, rsp_illegal=0.
  - cnt0=cnt1=0.
  - last_grant=1, so port 0 wins the first tie.
- Output stage FSM, two states:
  - EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
  - can_accept = EMPTY | (FULL & rsp_ready).
- Arbitration (combinational, every cycle):
  - Only one port valid: that port is granted.
  - Both ports valid: the port != last_grant is granted.
  - Neither valid: no grant.
- Handshakes:
  - reqN_ready = grantN & can_accept. It is never asserted for a port whose valid is low.
  - Ready depends on valid; valid must not depend on ready.
  - A requester holds valid, operands, sel and tag stable until ready is seen. Dropping valid before ready is legal; the request is simply withdrawn.
- Accept (reqN_valid & reqN_ready) in cycle N:
  - The granted port's a/b/sel feed the ALU.
  - rsp_data <= ALU result; rsp_src <= N; rsp_tag <= tag; rsp_illegal <= (sel > 4'b1010).
  - rsp_valid=1 in cycle N+1.
  - last_grant <= N; cntN increments.
  - last_grant updates only on accept, never on a mere grant.
- ALU op codes:
  - 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 nor, 6 slt (signed), 7 sltu, 8 sll, 9 srl, 10 sra.
  - Shifts use B[4:0]. Add/sub wrap modulo 2^32 with no overflow flag. slt/sltu return 0 or 1 zero-extended.
  - 11..15 return 0.
- State transitions:
  - FULL & !rsp_ready: all rsp_* outputs hold stable. No accept occurs, and both ready outputs are 0.
  - FULL & rsp_ready & accept: back-to-back operation; the new result replaces the old in the same edge and rsp_valid stays 1.
  - FULL & rsp_ready & no accept: goes to EMPTY; rsp_valid=0; rsp_data keeps its last value.
- Throughput: one result per cycle when the consumer is always ready. Under continuous dual requests, grants strictly alternate 0,1,0,1...
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Reset asserted mid-operation: the pending result is discarded with no response. Both ready outputs are 0 during the reset cycle. Counters and last_grant return to their reset values.

Decomposition:
- Shared package alu_pkg holds:
  - ALU_ADD..ALU_SRA localparams (4'b0000..4'b1010).
  - ALU_SEL_MAX = 4'b1010.
  - ALU_SEL_W = 4.
- alu_pkg is also used by the decoder.
- Sub-module: exactly one instance of the existing ALU module (ports A, B, ALU_SEL, ALU_OUT). The arbiter contains only the mux, FSM, registers and counters; there is no duplicate ALU logic.

Test Plan:
1. After reset, req0 only: a=5, b=7, sel=0, tag=3 -> req0_ready=1 in that cycle; next cycle rsp_valid=1, rsp_data=12, rsp_src=0, rsp_tag=3, cnt0=1.
2. Both ports valid continuously with rsp_ready=1: req0 sel=1 (a=1, b=2), req1 sel=6 (a=0xFFFFFFFF, b=0) -> responses alternate src 0,1,0,1 with data 0xFFFFFFFF, 1, 0xFFFFFFFF, 1; one result per cycle.
3. Backpressure: rsp_ready=0 for 3 cycles with FULL holding sra result 0xF0000000>>>4=0xFF000000 -> rsp_* stable, both readies 0; rsp_ready=1 releases it and the waiting request is accepted the same cycle.
4. Illegal op: req1 sel=13, a=b=0xFFFF -> rsp_data=0, rsp_illegal=1, rsp_src=1.
5. Reset mid-operation: accept, then assert reset the next cycle -> rsp_valid=0 on the following edge, cnt0=cnt1=0, and the first subsequent tie is granted to port 0.
6. Counter saturation with CNT_W=2: 5 accepts on port 0 -> cnt0 sequence 1,2,3,3,3.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU op-code definitions and output-stage state type, used by the ALU,
// the decoder and the round-robin arbiter.
package alu_pkg;
  localparam int ALU_SEL_W = 4;

  localparam logic [ALU_SEL_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_SEL_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [ALU_SEL_W-1:0] ALU_AND  = 4'b0010;
  localparam logic [ALU_SEL_W-1:0] ALU_OR   = 4'b0011;
  localparam logic [ALU_SEL_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [ALU_SEL_W-1:0] ALU_NOR  = 4'b0101;
  localparam logic [ALU_SEL_W-1:0] ALU_SLT  = 4'b0110;
  localparam logic [ALU_SEL_W-1:0] ALU_SLTU = 4'b0111;
  localparam logic [ALU_SEL_W-1:0] ALU_SLL  = 4'b1000;
  localparam logic [ALU_SEL_W-1:0] ALU_SRL  = 4'b1001;
  localparam logic [ALU_SEL_W-1:0] ALU_SRA  = 4'b1010;
  localparam logic [ALU_SEL_W-1:0] ALU_SEL_MAX = 4'b1010;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;
endpackage

// File: rtl/alu.sv
// 32-bit combinational ALU; op codes above ALU_SEL_MAX produce zero.
module alu
  import alu_pkg::*;
(
  input  logic [31:0]          A,
  input  logic [31:0]          B,
  input  logic [ALU_SEL_W-1:0] ALU_SEL,
  output logic [31:0]          ALU_OUT
);
  logic [4:0] shamt;
  assign shamt = B[4:0];

  always_comb begin
    ALU_OUT = '0;
    case (ALU_SEL)
      ALU_ADD:  ALU_OUT = A + B;
      ALU_SUB:  ALU_OUT = A - B;
      ALU_AND:  ALU_OUT = A & B;
      ALU_OR:   ALU_OUT = A | B;
      ALU_XOR:  ALU_OUT = A ^ B;
      ALU_NOR:  ALU_OUT = ~(A | B);
      ALU_SLT:  ALU_OUT = {31'd0, ($signed(A) < $signed(B))};
      ALU_SLTU: ALU_OUT = {31'd0, (A < B)};
      ALU_SLL:  ALU_OUT = A << shamt;
      ALU_SRL:  ALU_OUT = A >> shamt;
      ALU_SRA:  ALU_OUT = $unsigned($signed(A) >>> shamt);
      default:  ALU_OUT = '0;
    endcase
  end
endmodule

// File: rtl/alu_rr_arbiter.sv
// Two-port round-robin front end for one shared ALU with a single-entry
// registered result stage and saturating per-port grant counters.
module alu_rr_arbiter
  import alu_pkg::*;
#(
  parameter int DW    = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [DW-1:0]        req0_a,
  input  logic [DW-1:0]        req0_b,
  input  logic [ALU_SEL_W-1:0] req0_sel,
  input  logic [TAG_W-1:0]     req0_tag,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [DW-1:0]        req1_a,
  input  logic [DW-1:0]        req1_b,
  input  logic [ALU_SEL_W-1:0] req1_sel,
  input  logic [TAG_W-1:0]     req1_tag,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DW-1:0]        rsp_data,
  output logic                 rsp_src,
  output logic [TAG_W-1:0]     rsp_tag,
  output logic                 rsp_illegal,
  output logic [CNT_W-1:0]     cnt0,
  output logic [CNT_W-1:0]     cnt1
);
  out_state_e state, state_nxt;
  logic last_grant;
  logic grant0, grant1, can_accept, acc0, acc1, accept;
  logic [DW-1:0] mux_a, mux_b, alu_out;
  logic [ALU_SEL_W-1:0] mux_sel;
  logic [TAG_W-1:0] mux_tag;

  // On a tie the port that did not win the last accept gets the grant.
  assign grant0 = req0_valid & (!req1_valid | last_grant);
  assign grant1 = req1_valid & (!req0_valid | !last_grant);

  assign can_accept = (state == OUT_EMPTY) | rsp_ready;
  assign req0_ready = grant0 & can_accept & !reset;
  assign req1_ready = grant1 & can_accept & !reset;
  assign acc0       = req0_valid & req0_ready;
  assign acc1       = req1_valid & req1_ready;
  assign accept     = acc0 | acc1;

  assign mux_a   = grant1 ? req1_a   : req0_a;
  assign mux_b   = grant1 ? req1_b   : req0_b;
  assign mux_sel = grant1 ? req1_sel : req0_sel;
  assign mux_tag = grant1 ? req1_tag : req0_tag;

  alu u_alu (
    .A       (mux_a),
    .B       (mux_b),
    .ALU_SEL (mux_sel),
    .ALU_OUT (alu_out)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      OUT_EMPTY: if (accept) state_nxt = OUT_FULL;
      OUT_FULL:  if (rsp_ready && !accept) state_nxt = OUT_EMPTY;
      default:   state_nxt = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= OUT_EMPTY;
    else       state <= state_nxt;
  end

  assign rsp_valid = (state == OUT_FULL);

  // Payload registers only load on accept, so a drained stage keeps its data.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_data    <= '0;
      rsp_src     <= 1'b0;
      rsp_tag     <= '0;
      rsp_illegal <= 1'b0;
      last_grant  <= 1'b1;
    end else if (accept) begin
      rsp_data    <= alu_out;
      rsp_src     <= acc1;
      rsp_tag     <= mux_tag;
      rsp_illegal <= (mux_sel > ALU_SEL_MAX);
      last_grant  <= acc1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (acc0 && (cnt0 != {CNT_W{1'b1}})) cnt0 <= cnt0 + 1'b1;
      if (acc1 && (cnt1 != {CNT_W{1'b1}})) cnt1 <= cnt1 + 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed self-checking bench for alu_rr_arbiter (counters built 2 bits wide
// so saturation is reachable quickly).
module tb_alu_rr_arbiter;
  localparam int DW = 32, TAG_W = 5, CNT_W = 2;

  logic clk = 1'b0, reset = 1'b1;
  logic req0_valid = 0, req1_valid = 0, rsp_ready = 0;
  logic req0_ready, req1_ready, rsp_valid, rsp_src, rsp_illegal;
  logic [DW-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0, rsp_data;
  logic [3:0] req0_sel = 0, req1_sel = 0;
  logic [TAG_W-1:0] req0_tag = 0, req1_tag = 0, rsp_tag;
  logic [CNT_W-1:0] cnt0, cnt1;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  alu_rr_arbiter #(.DW(DW), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_sel(req0_sel), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_sel(req1_sel), .req1_tag(req1_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_src(rsp_src),
    .rsp_tag(rsp_tag), .rsp_illegal(rsp_illegal), .cnt0(cnt0), .cnt1(cnt1)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1; req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    tick();
    reset = 0; #1;
  endtask

  task automatic test_reset();
    reset = 1; req0_valid = 1; req1_valid = 1; rsp_ready = 1; #1;
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_bad++; $display("FAIL reset_ready got=%b want=00", {req0_ready, req1_ready}); end
    tick();
    reset = 0; req0_valid = 0; req1_valid = 0; #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b want=0", rsp_valid); end
    n_cmp++; if ({rsp_data, rsp_src, rsp_tag, rsp_illegal} !== '0) begin n_bad++; $display("FAIL reset_rsp got data=%h src=%b tag=%0d ill=%b want all 0", rsp_data, rsp_src, rsp_tag, rsp_illegal); end
    n_cmp++; if ({cnt0, cnt1} !== '0) begin n_bad++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", cnt0, cnt1); end
  endtask

  task automatic test_single();
    do_reset();
    req0_valid = 1; req0_a = 5; req0_b = 7; req0_sel = 0; req0_tag = 3; rsp_ready = 1; #1;
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_bad++; $display("FAIL single_ready got=%b want=10", {req0_ready, req1_ready}); end
    tick();
    req0_valid = 0; #1;
    n_cmp++; if ({rsp_valid, rsp_data, rsp_src, rsp_tag} !== {1'b1, 32'd12, 1'b0, 5'd3}) begin n_bad++; $display("FAIL single_rsp got v=%b d=%0d s=%b t=%0d want v=1 d=12 s=0 t=3", rsp_valid, rsp_data, rsp_src, rsp_tag); end
    n_cmp++; if (cnt0 !== 2'd1 || rsp_illegal !== 1'b0) begin n_bad++; $display("FAIL single_cnt got cnt0=%0d ill=%b want 1/0", cnt0, rsp_illegal); end
    tick();
    n_cmp++; if (rsp_valid !== 1'b0 || rsp_data !== 32'd12) begin n_bad++; $display("FAIL single_drain got v=%b d=%0d want v=0 d=12", rsp_valid, rsp_data); end
  endtask

  logic [31:0] op_a [9] = '{32'hF0F000FF, 32'hF0F000FF, 32'hF0F000FF, 32'hF0F000FF, 32'd1, 32'd1, 32'd1, 32'h80000000, 32'hFFFFFFFF};
  logic [31:0] op_b [9] = '{32'h0FF00F0F, 32'h0FF00F0F, 32'h0FF00F0F, 32'h0FF00F0F, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h23, 32'd4, 32'd2};
  logic [3:0]  op_s [9] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd6, 4'd8, 4'd9, 4'd0};
  logic [31:0] op_r [9] = '{32'h00F0000F, 32'hFFF00FFF, 32'hFF000FF0, 32'h000FF000, 32'd1, 32'd0, 32'd8, 32'h08000000, 32'd1};

  task automatic test_ops();
    do_reset();
    rsp_ready = 1;
    for (int i = 0; i < 9; i++) begin
      req0_valid = 1; req0_a = op_a[i]; req0_b = op_b[i]; req0_sel = op_s[i]; req0_tag = 5'(i);
      tick();
      n_cmp++; if ({rsp_valid, rsp_data, rsp_tag} !== {1'b1, op_r[i], 5'(i)}) begin n_bad++; $display("FAIL op_sel%0d got v=%b d=%h t=%0d want d=%h", op_s[i], rsp_valid, rsp_data, rsp_tag, op_r[i]); end
    end
    req0_valid = 0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d;
    do_reset();
    rsp_ready = 1;
    req0_valid = 1; req0_a = 1; req0_b = 2; req0_sel = 1; req0_tag = 1;
    req1_valid = 1; req1_a = 32'hFFFFFFFF; req1_b = 0; req1_sel = 6; req1_tag = 2; #1;
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_bad++; $display("FAIL rr_first got=%b want=10", {req0_ready, req1_ready}); end
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_d = (i % 2 == 0) ? 32'hFFFFFFFF : 32'd1;
      n_cmp++; if ({rsp_valid, rsp_src, rsp_data} !== {1'b1, 1'(i % 2), exp_d}) begin n_bad++; $display("FAIL rr_rsp%0d got v=%b s=%b d=%h want s=%0d d=%h", i, rsp_valid, rsp_src, rsp_data, i % 2, exp_d); end
      n_cmp++; if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin n_bad++; $display("FAIL rr_ready%0d got=%b", i, {req0_ready, req1_ready}); end
    end
    n_cmp++; if ({cnt0, cnt1} !== {2'd2, 2'd2}) begin n_bad++; $display("FAIL rr_cnt got=%0d/%0d want=2/2", cnt0, cnt1); end
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic test_backpressure();
    do_reset();
    rsp_ready = 1;
    req1_valid = 1; req1_a = 32'hF0000000; req1_b = 4; req1_sel = 10; req1_tag = 7;
    tick();
    req1_valid = 0; rsp_ready = 0;
    req0_valid = 1; req0_a = 1; req0_b = 1; req0_sel = 0; req0_tag = 2;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if ({rsp_valid, rsp_data, rsp_src, rsp_tag} !== {1'b1, 32'hFF000000, 1'b1, 5'd7}) begin n_bad++; $display("FAIL bp_hold%0d got v=%b d=%h s=%b t=%0d want v=1 d=ff000000 s=1 t=7", i, rsp_valid, rsp_data, rsp_src, rsp_tag); end
      n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_bad++; $display("FAIL bp_ready%0d got=%b want=00", i, {req0_ready, req1_ready}); end
      tick();
    end
    rsp_ready = 1; #1;
    n_cmp++; if (req0_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release got=%b want=1", req0_ready); end
    tick();
    req0_valid = 0; #1;
    n_cmp++; if ({rsp_valid, rsp_data, rsp_src, rsp_tag} !== {1'b1, 32'd2, 1'b0, 5'd2}) begin n_bad++; $display("FAIL bp_next got v=%b d=%h s=%b t=%0d want v=1 d=2 s=0 t=2", rsp_valid, rsp_data, rsp_src, rsp_tag); end
  endtask

  task automatic test_illegal();
    do_reset();
    rsp_ready = 1;
    req1_valid = 1; req1_a = 32'hFFFF; req1_b = 32'hFFFF; req1_sel = 13; req1_tag = 9;
    tick();
    req1_valid = 0;
    n_cmp++; if ({rsp_valid, rsp_data, rsp_illegal, rsp_src} !== {1'b1, 32'd0, 1'b1, 1'b1}) begin n_bad++; $display("FAIL illegal got v=%b d=%h ill=%b s=%b want v=1 d=0 ill=1 s=1", rsp_valid, rsp_data, rsp_illegal, rsp_src); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rsp_ready = 1;
    req0_valid = 1; req0_a = 3; req0_b = 4; req0_sel = 0; req0_tag = 1;
    tick();
    reset = 1; req1_valid = 1; #1;
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_bad++; $display("FAIL rstmid_ready got=%b want=00", {req0_ready, req1_ready}); end
    tick();
    reset = 0; #1;
    n_cmp++; if ({rsp_valid, cnt0, cnt1} !== {1'b0, 2'd0, 2'd0}) begin n_bad++; $display("FAIL rstmid_state got v=%b cnt=%0d/%0d want 0 0/0", rsp_valid, cnt0, cnt1); end
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_bad++; $display("FAIL rstmid_tie got=%b want=10", {req0_ready, req1_ready}); end
    req0_valid = 0; req1_valid = 0;
  endtask

  logic [1:0] sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  task automatic test_saturation();
    do_reset();
    rsp_ready = 1;
    req0_valid = 1; req0_a = 0; req0_b = 0; req0_sel = 0; req0_tag = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (cnt0 !== sat_exp[i]) begin n_bad++; $display("FAIL sat%0d got=%0d want=%0d", i, cnt0, sat_exp[i]); end
    end
    req0_valid = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_ops();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
